stream_demux2: RTL and testbench

Two-way stream demultiplexer with per-packet routing and a one-beat output register. An upstream valid/ready stream enters, and each packet is steered whole to port A or port B. The route is picked on the packet's first beat by the same select rule the datapath muxes use: B when `sel_b1 && sel_b2`, else A. It sits between a shared producer and two consumers, and is the splitting counterpart of the 2:1 select muxes.

---
 rtl/stream_demux2_if.sv | 32 +++
 rtl/stream_demux2.sv | 86 ++++++++
 tb/tb_stream_demux2.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux2_if.sv
// rtl/stream_demux2_if.sv - handshake bundle between the shared producer, the demux and its two consumers
interface stream_demux2_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              sel_b1;
  logic              sel_b2;
  logic [DATA_W-1:0] a_data;
  logic              a_valid;
  logic              a_last;
  logic              a_ready;
  logic [DATA_W-1:0] b_data;
  logic              b_valid;
  logic              b_last;
  logic              b_ready;
  logic              busy;

  // master: producer and consumers around the demux
  modport master (
    output in_data, in_valid, in_last, sel_b1, sel_b2, a_ready, b_ready,
    input  in_ready, a_data, a_valid, a_last, b_data, b_valid, b_last, busy
  );

  // slave: the demux itself
  modport slave (
    input  in_data, in_valid, in_last, sel_b1, sel_b2, a_ready, b_ready,
    output in_ready, a_data, a_valid, a_last, b_data, b_valid, b_last, busy
  );
endinterface

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - two-way packet demux; route chosen on a packet's first beat, one-beat output register
module stream_demux2 #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux2_if.slave bus
);
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              lock_dest;
  logic              lock_dest_nxt;
  logic              dest;

  logic              r_valid;
  logic              r_dest;
  logic              r_last;
  logic [DATA_W-1:0] r_data;

  logic              in_fire;
  logic              out_fire;

  // only the held beat's own port can drain it; the other ready is ignored
  assign out_fire     = r_valid && (r_dest ? bus.b_ready : bus.a_ready);
  assign bus.in_ready = !r_valid || out_fire;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_dest <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_dest <= lock_dest_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lock_dest_nxt = lock_dest;
    dest          = lock_dest;
    case (state)
      IDLE: begin
        dest = bus.sel_b1 && bus.sel_b2;
        if (in_fire) begin
          lock_dest_nxt = dest;
          if (!bus.in_last) state_nxt = PKT;
        end
      end
      PKT: begin
        if (in_fire && bus.in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a load in the same cycle as a drain simply replaces the old beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dest  <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (in_fire) begin
      r_valid <= 1'b1;
      r_dest  <= dest;
      r_last  <= bus.in_last;
      r_data  <= bus.in_data;
    end else if (out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.a_valid = r_valid && !r_dest;
  assign bus.b_valid = r_valid && r_dest;
  assign bus.a_data  = r_data;
  assign bus.b_data  = r_data;
  assign bus.a_last  = r_last;
  assign bus.b_last  = r_last;
  assign bus.busy    = (state == PKT);
endmodule

// File: tb/tb_stream_demux2.sv
// tb/tb_stream_demux2.sv - directed and randomized checks of stream_demux2 against a packet-level scoreboard
module tb_stream_demux2;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errs;

  stream_demux2_if #(.DATA_W(8)) bus ();

  stream_demux2 #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic s1, input logic s2);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.sel_b1   = s1;
    bus.sel_b2   = s2;
  endtask

  // expected beats per port as {last, data}
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  bit         m_open;
  bit         m_dest;
  bit         d;
  logic [8:0] got;

  initial begin
    vectors = 0;
    errs    = 0;
    rst_n   = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    tick();
    tick();
    chk("rst_a_valid", bus.a_valid, 1'b0);
    chk("rst_b_valid", bus.b_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // single beat, only one select high -> A
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t1_a_valid", bus.a_valid, 1'b1);
    chk("t1_a_data", bus.a_data, 8'h5A);
    chk("t1_a_last", bus.a_last, 1'b1);
    chk("t1_b_valid", bus.b_valid, 1'b0);
    chk("t1_busy", bus.busy, 1'b0);
    tick();
    chk("t1_drained", bus.a_valid, 1'b0);

    // three-beat packet locked to B despite sel_b2 dropping
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t2_b0_valid", bus.b_valid, 1'b1);
    chk("t2_b0_data", bus.b_data, 8'h11);
    chk("t2_b0_last", bus.b_last, 1'b0);
    chk("t2_b0_busy", bus.busy, 1'b1);
    drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t2_b1_valid", bus.b_valid, 1'b1);
    chk("t2_b1_a_valid", bus.a_valid, 1'b0);
    chk("t2_b1_data", bus.b_data, 8'h22);
    chk("t2_b1_busy", bus.busy, 1'b1);
    drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t2_b2_valid", bus.b_valid, 1'b1);
    chk("t2_b2_a_valid", bus.a_valid, 1'b0);
    chk("t2_b2_data", bus.b_data, 8'h33);
    chk("t2_b2_last", bus.b_last, 1'b1);
    chk("t2_b2_busy", bus.busy, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_drained", bus.b_valid, 1'b0);

    // backpressure on B; A ready must not drain it
    bus.b_ready = 1'b0;
    drive(1'b1, 8'h44, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t3_in_ready_stall", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_valid", bus.b_valid, 1'b1);
      chk("t3_hold_data", bus.b_data, 8'h44);
      chk("t3_hold_a_valid", bus.a_valid, 1'b0);
    end
    bus.b_ready = 1'b1;
    #1;
    chk("t3_in_ready_resume", bus.in_ready, 1'b1);
    tick();
    chk("t3_next_data", bus.b_data, 8'h55);
    chk("t3_next_valid", bus.b_valid, 1'b1);
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t3_last_data", bus.b_data, 8'h66);
    chk("t3_last_last", bus.b_last, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t3_drained", bus.b_valid, 1'b0);

    // back-to-back single-beat packets A, B, A
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t4_a0_valid", bus.a_valid, 1'b1);
    chk("t4_a0_data", bus.a_data, 8'h01);
    drive(1'b1, 8'h02, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t4_in_ready0", bus.in_ready, 1'b1);
    tick();
    chk("t4_b_valid", bus.b_valid, 1'b1);
    chk("t4_b_data", bus.b_data, 8'h02);
    chk("t4_b_a_valid", bus.a_valid, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
    #1;
    chk("t4_in_ready1", bus.in_ready, 1'b1);
    tick();
    chk("t4_a1_valid", bus.a_valid, 1'b1);
    chk("t4_a1_data", bus.a_data, 8'h03);
    chk("t4_a1_b_valid", bus.b_valid, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    // reset mid-packet with a held B beat
    bus.b_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t5_pre_b_valid", bus.b_valid, 1'b1);
    chk("t5_pre_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_b_valid", bus.b_valid, 1'b0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_in_ready", bus.in_ready, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.b_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h88, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t5_post_a_valid", bus.a_valid, 1'b1);
    chk("t5_post_a_data", bus.a_data, 8'h88);
    chk("t5_post_b_valid", bus.b_valid, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    // random sweep against a packet-level scoreboard
    m_open = 1'b0;
    m_dest = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc < 1400) begin
        drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
              1'($urandom), 1'($urandom));
        bus.a_ready = $urandom_range(0, 3) != 0;
        bus.b_ready = $urandom_range(0, 3) != 0;
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
      end
      @(negedge clk);
      chk("rnd_one_hot", bus.a_valid && bus.b_valid, 1'b0);
      chk("rnd_in_ready", bus.in_ready,
          !(bus.a_valid || bus.b_valid) || (bus.a_valid && bus.a_ready) ||
          (bus.b_valid && bus.b_ready));
      if (bus.a_valid && bus.a_ready) begin
        chk("rnd_a_nonempty", exp_a.size() != 0, 1'b1);
        if (exp_a.size() != 0) begin
          got = exp_a.pop_front();
          chk("rnd_a_beat", {bus.a_last, bus.a_data}, got);
        end
      end
      if (bus.b_valid && bus.b_ready) begin
        chk("rnd_b_nonempty", exp_b.size() != 0, 1'b1);
        if (exp_b.size() != 0) begin
          got = exp_b.pop_front();
          chk("rnd_b_beat", {bus.b_last, bus.b_data}, got);
        end
      end
      chk("rnd_busy", bus.busy, m_open);
      if (bus.in_valid && bus.in_ready) begin
        d = m_open ? m_dest : (bus.sel_b1 && bus.sel_b2);
        m_dest = d;
        m_open = !bus.in_last;
        if (d) exp_b.push_back({bus.in_last, bus.in_data});
        else   exp_a.push_back({bus.in_last, bus.in_data});
      end
      tick();
    end
    chk("rnd_a_empty", exp_a.size(), 0);
    chk("rnd_b_empty", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
